// File: rtl/pattern_generator_param.sv
// Parametrised tile/bar/gradient/solid test-pattern source with explicit X/Y raster counters.
// Optional border overlay: define PATTERN_GENERATOR_BORDER_EN.
module pattern_generator_param #(
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 600,
    parameter int TILE_W          = 80,
    parameter int TILE_H          = 50,
    parameter int CHANNEL_WIDTH   = 8,
    parameter int FRAMES_PER_PAGE = 72,
    parameter int GRAD_SHIFT      = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [1:0]                 Mode,
    input  logic                       VideoReady,
    output logic                       VideoValid,
    output logic [3*CHANNEL_WIDTH-1:0] Video,
    output logic                       StartOfFrame,
    output logic                       EndOfLine,
    output logic                       PageIndex
);

    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int TILES_X = (H_ACTIVE + TILE_W - 1) / TILE_W;
    localparam int TILES_Y = (V_ACTIVE + TILE_H - 1) / TILE_H;
    localparam int TXW     = ($clog2(TILES_X) > 2) ? $clog2(TILES_X) : 2;
    localparam int TYW     = ($clog2(TILES_Y) > 2) ? $clog2(TILES_Y) : 2;
    localparam int PXW     = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int LNW     = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int FCW     = (FRAMES_PER_PAGE > 1) ? $clog2(FRAMES_PER_PAGE) : 1;
    localparam int CW      = CHANNEL_WIDTH;

    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [TXW-1:0] tile_x;
    logic [TYW-1:0] tile_y;
    logic [PXW-1:0] px_cnt;
    logic [LNW-1:0] ln_cnt;
    logic [FCW-1:0] frame_cnt;
    logic [1:0]     mode_q;
    logic           page;
    logic           valid;

    // Handshake: a pixel moves when VideoValid && VideoReady on a rising Clock edge;
    // while VideoReady is low the presented pixel and markers hold unchanged.
    logic xfer;
    logic line_end;
    logic frame_end;

    assign xfer      = valid && VideoReady;
    assign line_end  = (x == XW'(H_ACTIVE - 1));
    assign frame_end = line_end && (y == YW'(V_ACTIVE - 1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x         <= '0;
            y         <= '0;
            tile_x    <= '0;
            tile_y    <= '0;
            px_cnt    <= '0;
            ln_cnt    <= '0;
            frame_cnt <= '0;
            mode_q    <= '0;
            page      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b1;
            if (xfer) begin
                if (line_end) begin
                    x      <= '0;
                    px_cnt <= '0;
                    tile_x <= '0;
                    if (frame_end) begin
                        y      <= '0;
                        ln_cnt <= '0;
                        tile_y <= '0;
                        // New mode takes effect exactly at the next frame's first pixel.
                        mode_q <= Mode;
                        if (frame_cnt == FCW'(FRAMES_PER_PAGE - 1)) begin
                            frame_cnt <= '0;
                            page      <= ~page;
                        end else begin
                            frame_cnt <= frame_cnt + FCW'(1);
                        end
                    end else begin
                        y <= y + YW'(1);
                        if (ln_cnt == LNW'(TILE_H - 1)) begin
                            ln_cnt <= '0;
                            tile_y <= tile_y + TYW'(1);
                        end else begin
                            ln_cnt <= ln_cnt + LNW'(1);
                        end
                    end
                end else begin
                    x <= x + XW'(1);
                    if (px_cnt == PXW'(TILE_W - 1)) begin
                        px_cnt <= '0;
                        tile_x <= tile_x + TXW'(1);
                    end else begin
                        px_cnt <= px_cnt + PXW'(1);
                    end
                end
            end
        end
    end

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'h8E44AD;
            3'd1:    return 24'h2C3E50;
            3'd2:    return 24'h16A085;
            3'd3:    return 24'h2980B9;
            3'd4:    return 24'h1ABC9C;
            3'd5:    return 24'hE67E22;
            3'd6:    return 24'hF1C40F;
            default: return 24'h2ECC71;
        endcase
    endfunction

    logic [1:0]    k;
    logic [2:0]    pal_idx;
    logic [23:0]   pal_rgb;
    logic [CW-1:0] pal_r;
    logic [CW-1:0] pal_g;
    logic [CW-1:0] pal_b;
    logic [CW-1:0] grad;
    logic [3*CW-1:0] pattern;

    always_comb begin
        k = 2'd0;
        case (mode_q)
            2'd0:    k = {tile_y[0], tile_x[0]};
            2'd1:    k = tile_x[1:0];
            default: k = 2'd0;
        endcase
        pal_idx = {page, k};
        pal_rgb = palette(pal_idx);
    end

    // Narrow channels keep the palette MSBs; wide channels left-justify with zero LSBs.
    if (CW <= 8) begin : g_narrow
        assign pal_r = pal_rgb[23 -: CW];
        assign pal_g = pal_rgb[15 -: CW];
        assign pal_b = pal_rgb[7 -: CW];
    end else begin : g_wide
        assign pal_r = {pal_rgb[23:16], {(CW - 8){1'b0}}};
        assign pal_g = {pal_rgb[15:8],  {(CW - 8){1'b0}}};
        assign pal_b = {pal_rgb[7:0],   {(CW - 8){1'b0}}};
    end

    always_comb begin
        grad = CW'(x >> GRAD_SHIFT);
        if (page) begin
            grad = ~grad;
        end
        if (mode_q == 2'd2) begin
            pattern = {grad, grad, grad};
        end else begin
            pattern = {pal_r, pal_g, pal_b};
        end
    end

`ifdef PATTERN_GENERATOR_BORDER_EN
    logic border;
    assign border = (x == '0) || line_end || (y == '0) || (y == YW'(V_ACTIVE - 1));
    assign Video  = border ? '1 : pattern;
`else
    assign Video  = pattern;
`endif

    assign VideoValid   = valid;
    assign StartOfFrame = (x == '0) && (y == '0);
    assign EndOfLine    = line_end;
    assign PageIndex    = page;

endmodule

// File: tb/tb_pattern_generator_param.sv
// Bench for pattern_generator_param: vector table, hand sequences for mode/reset corners,
// and a randomized VideoReady/Mode run against a pixel-index reference model.
module tb_pattern_generator_param;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int TW    = 2;
    localparam int TH    = 2;
    localparam int CW    = 4;
    localparam int FPP   = 2;
    localparam int GS    = 0;
    localparam int FRAME = H * V;

    logic            Clock = 1'b0;
    logic            Reset = 1'b0;
    logic [1:0]      Mode = 2'd0;
    logic            VideoReady = 1'b0;
    logic            VideoValid;
    logic [3*CW-1:0] Video;
    logic            StartOfFrame;
    logic            EndOfLine;
    logic            PageIndex;

    pattern_generator_param #(
        .H_ACTIVE(H), .V_ACTIVE(V), .TILE_W(TW), .TILE_H(TH),
        .CHANNEL_WIDTH(CW), .FRAMES_PER_PAGE(FPP), .GRAD_SHIFT(GS)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Mode(Mode), .VideoReady(VideoReady),
        .VideoValid(VideoValid), .Video(Video), .StartOfFrame(StartOfFrame),
        .EndOfLine(EndOfLine), .PageIndex(PageIndex)
    );

    // clock / watchdog
    always #5 Clock = ~Clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    int vectors = 0;
    int miscompares = 0;

    // reference model state: pixels transferred since reset, mode of current frame
    int         n;
    logic [1:0] m_mode;
    logic       m_valid;

    int pal_r[8] = '{142, 44, 22, 41, 26, 230, 241, 46};
    int pal_g[8] = '{68, 62, 160, 128, 188, 126, 196, 204};
    int pal_b[8] = '{173, 80, 133, 185, 156, 34, 15, 113};

    typedef struct {
        int          idx;
        logic [11:0] video;
        logic        sof;
        logic        eol;
        logic        page;
    } vec_t;
    vec_t tbl[12];

    function automatic bit on_border(input int idx);
        int pos;
        pos = idx % FRAME;
`ifdef PATTERN_GENERATOR_BORDER_EN
        return (pos % H == 0) || (pos % H == H - 1) || (pos / H == 0) || (pos / H == V - 1);
`else
        return (pos < 0);
`endif
    endfunction

    function automatic logic [11:0] exp_video(input int idx, input logic [1:0] md);
        int pos, x, y, page, tx, ty, k, p, gv;
        pos  = idx % FRAME;
        x    = pos % H;
        y    = pos / H;
        page = (idx / FRAME / FPP) % 2;
        tx   = x / TW;
        ty   = y / TH;
        if (on_border(idx)) return 12'hFFF;
        if (md == 2'd2) begin
            gv = (x >> GS) % 16;
            if (page == 1) gv = 15 - gv;
            return {gv[3:0], gv[3:0], gv[3:0]};
        end
        if (md == 2'd0)      k = 2 * (ty % 2) + (tx % 2);
        else if (md == 2'd1) k = tx % 4;
        else                 k = 0;
        p = 4 * page + k;
        return {4'(pal_r[p] >> 4), 4'(pal_g[p] >> 4), 4'(pal_b[p] >> 4)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (pixel %0d): got %h, expected %h", name, n, act, exp);
        end
    endtask

    task automatic check_model();
        int pos;
        logic [15:0] exp;
        pos = n % FRAME;
        exp = {m_valid, exp_video(n, m_mode), pos == 0, (pos % H) == H - 1,
               ((n / FRAME / FPP) % 2) == 1};
        check("pixel", {VideoValid, Video, StartOfFrame, EndOfLine, PageIndex}, exp);
    endtask

    // driver tasks
    task automatic cycle(input logic rdy, input logic [1:0] md);
        VideoReady = rdy;
        Mode       = md;
        @(posedge Clock);
        if (m_valid && rdy) begin
            if (n % FRAME == FRAME - 1) m_mode = md;
            n++;
        end
        m_valid = 1'b1;
        @(negedge Clock);
        check_model();
    endtask

    task automatic do_reset();
        Reset   = 1'b0;
        n       = 0;
        m_mode  = 2'd0;
        m_valid = 1'b0;
        #1;
        check_model();
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic run_to(input int target, input logic [1:0] md);
        int budget;
        budget = 0;
        while (n < target && budget < 1000) begin
            cycle(1'b1, md);
            budget++;
        end
        vectors++;
        if (n != target) begin
            miscompares++;
            $display("FAIL run_to: reached pixel %0d, required %0d", n, target);
        end
    endtask

    logic [11:0] bars[6] = '{12'h84A, 12'h235, 12'h235, 12'h1A8, 12'h1A8, 12'h28B};

    initial begin
        tbl[0]  = '{0,   12'h84A, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2,   12'h235, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{7,   12'h235, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{16,  12'h1A8, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{18,  12'h28B, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{31,  12'h28B, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{32,  12'h84A, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{64,  12'h1B9, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{66,  12'hE72, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{80,  12'hFC0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{82,  12'h2C7, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{128, 12'h84A, 1'b1, 1'b0, 1'b0};

        // checker mode, VideoReady held high, page toggles every two frames
        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_to(tbl[i].idx, 2'd0);
            check("table", {1'b0, Video, StartOfFrame, EndOfLine, PageIndex},
                  {1'b0, on_border(tbl[i].idx) ? 12'hFFF : tbl[i].video,
                   tbl[i].sof, tbl[i].eol, tbl[i].page});
        end

        // mode 0->1 mid-frame at X=3,Y=1: bars only from the next frame
        do_reset();
        run_to(11, 2'd0);
        run_to(41, 2'd1);
        for (int i = 0; i < 6; i++) begin
            check("bar", {4'b0, Video}, {4'b0, bars[i]});
            cycle(1'b1, 2'd1);
        end
        // gradient: frame 2 is page 1 (inverted), frame 4 is page 0
        run_to(73, 2'd2);
        for (int i = 1; i < 7; i++) begin
            check("grad_inv", {4'b0, Video}, {4'b0, 4'(15 - i), 4'(15 - i), 4'(15 - i)});
            cycle(1'b1, 2'd2);
        end
        run_to(137, 2'd2);
        for (int i = 1; i < 7; i++) begin
            check("grad", {4'b0, Video}, {4'b0, 4'(i), 4'(i), 4'(i)});
            cycle(1'b1, 2'd2);
        end

        // reset mid-frame at X=5,Y=2 clears without a clock edge
        do_reset();
        run_to(21, 2'd0);
        do_reset();
        check("reset_mid", {14'b0, VideoValid, StartOfFrame}, {14'b0, 1'b0, 1'b1});
        cycle(1'b1, 2'd0);
        check("restart", {14'b0, VideoValid, StartOfFrame}, {14'b0, 1'b1, 1'b1});
`ifdef PATTERN_GENERATOR_BORDER_EN
        check("corner", {4'b0, Video}, {4'b0, 12'hFFF});
`endif

        // randomized VideoReady and Mode against the reference model
        do_reset();
        repeat (1500) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_generator_param.md
Name: pattern_generator_param

Overview:
- Parametrised successor to the fixed 8-colour tile pattern source; feeds the video output path as a test-pattern stream.
- Explicit X/Y raster counters, configurable raster/tile geometry and channel width, four runtime patterns, and a palette page that toggles every FRAMES_PER_PAGE frames.
- Streams one pixel per accepted VideoValid/VideoReady transfer, with start-of-frame and end-of-line markers.

Parameters:
- H_ACTIVE, 800, pixels per line (>=2)
- V_ACTIVE, 600, lines per frame (>=2)
- TILE_W, 80, tile width in pixels (>=1; partial last tile allowed)
- TILE_H, 50, tile height in lines (>=1; partial last tile allowed)
- CHANNEL_WIDTH, 8, bits per colour channel (1..12)
- FRAMES_PER_PAGE, 72, frames per palette page (>=1)
- GRAD_SHIFT, 2, right shift applied to X for gradient mode

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Mode  in  2  pattern select: 0 checker, 1 vertical bars, 2 gradient, 3 solid
- VideoReady  in  1  downstream accepts pixel this cycle
- VideoValid  out  1  pixel on Video is valid
- Video  out  3*CHANNEL_WIDTH  {R,G,B}, R in MSBs
- StartOfFrame  out  1  current pixel is X=0, Y=0
- EndOfLine  out  1  current pixel is X=H_ACTIVE-1
- PageIndex  out  1  current palette page

Behaviour:
- Reset low: X=Y=0, tile counters=0, frame count=0, PageIndex=0, mode register=0, VideoValid=0. Video and markers decode from these registers.
- VideoValid rises on the first Clock edge after Reset deasserts and stays high until the next reset.
- A transfer occurs when VideoValid && VideoReady. Counters change only on a transfer; otherwise Video and markers hold.
- Video, StartOfFrame and EndOfLine are combinational from registered state, giving zero latency from state to output.
- Raster advance: on transfer, X+1. When X=H_ACTIVE-1, X wraps to 0 and Y+1. When Y=V_ACTIVE-1 on a line wrap, Y wraps to 0 and the frame ends.
- tile_x advances when the in-tile pixel count reaches TILE_W-1. tile_x and the in-tile pixel count clear at line end.
- tile_y advances when the in-tile line count reaches TILE_H-1. tile_y and the in-tile line count clear at frame end.
- Page: on frame end, if frame count = FRAMES_PER_PAGE-1 then PageIndex toggles and frame count clears; else frame count +1. FRAMES_PER_PAGE=1 toggles the page every frame.
- Mode register loads from Mode on the transfer of the last pixel of a frame, so the new mode applies from the next X=0,Y=0. Mode changes mid-frame are ignored until then.
- Palette index p = 4*PageIndex + k, where:
  - mode 0: k = 2*tile_y[0] + tile_x[0]
  - mode 1: k = tile_x mod 4
  - mode 3: k = 0
- Mode 2 bypasses the palette: R=G=B = (X >> GRAD_SHIFT) truncated to CHANNEL_WIDTH. On page 1 the gradient value is inverted.
- Palette (8-bit R,G,B):
  - 0 (142,68,173), 1 (44,62,80), 2 (22,160,133), 3 (41,128,185)
  - 4 (26,188,156), 5 (230,126,34), 6 (241,196,15), 7 (46,204,113)
- Palette width rule: CHANNEL_WIDTH<=8 uses the top CHANNEL_WIDTH bits; CHANNEL_WIDTH>8 left-justifies with zero-filled LSBs.
- Reset mid-frame clears immediately, independent of Clock. Stream restarts at X=0,Y=0, page 0, mode 0.

Optional Feature:
- Macro PATTERN_GENERATOR_BORDER_EN.
- Defined: pixels with X=0, X=H_ACTIVE-1, Y=0 or Y=V_ACTIVE-1 output all-ones on every channel, overriding every mode.
- Undefined: no border logic; output is the pattern only.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4, TILE_W=2, TILE_H=2, FRAMES_PER_PAGE=2, Mode=0, VideoReady=1 -> line 0 colours idx 0,0,1,1,0,0,1,1; line 2 idx 2,2,3,3...; EndOfLine high at X=7; StartOfFrame high once per 32 transfers.
- Same config, run 2 frames -> PageIndex=1 from transfer 64; first pixel = (26,188,156). Run 2 more frames -> PageIndex=0 at transfer 128.
- VideoReady toggled pseudo-randomly -> Video and markers constant while VideoReady=0; pixel sequence identical to the VideoReady=1 run.
- Mode changed 0->1 at X=3,Y=1 -> checker continues to frame end; frame 2 shows bar idx 0,0,1,1,2,2,3,3.
- Mode=2, GRAD_SHIFT=0, CHANNEL_WIDTH=4 -> R=G=B=X (0..7) on page 0; 15-X on page 1.
- Reset asserted at X=5,Y=2 -> immediately VideoValid=0, X=Y=0; one clock after release VideoValid=1, StartOfFrame=1. With BORDER_EN defined, corner pixel = all-ones.
